// File: rtl/uart_tx_fifo_if.sv
// Host-side write handshake for uart_tx_fifo: word, valid, ready.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO, clock-enable bit timer and
// configurable frame format. Optional parity bit: define UART_TX_PARITY_EN.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [DIV_WIDTH-1:0]          clock_div,
  input  logic                          parity_odd,
  uart_tx_fifo_if.slave                 bus,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP
`ifdef UART_TX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 push, pop;

  assign bus.tx_ready = (count != CW'(FIFO_DEPTH));
  assign push         = bus.tx_valid && bus.tx_ready;
  assign fifo_count   = count;

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= bus.tx_data;
  end

  // Pointers wrap modulo depth; count tracks occupancy, simultaneous push/pop cancel.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM
  state_t               state, state_nxt;
  logic [DIV_WIDTH-1:0] timer, div_lat;
  logic [DATA_BITS-1:0] shreg;
  logic [IW-1:0]        bit_idx;
  logic                 stop_cnt;
  logic                 tx_q, tx_d, done_q, done_d;
  logic                 bit_end, last_bit, last_stop;

  assign bit_end   = (timer == div_lat);
  assign last_bit  = (bit_idx == IW'(DATA_BITS - 1));
  assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));

`ifdef UART_TX_PARITY_EN
  logic par_q;
`else
  logic unused_parity;
  assign unused_parity = parity_odd;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state and FIFO pop; a pop always launches a new frame.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: if (count != '0) begin
        pop       = 1'b1;
        state_nxt = S_START;
      end
      S_START: if (bit_end) state_nxt = S_DATA;
`ifdef UART_TX_PARITY_EN
      S_DATA:   if (bit_end && last_bit) state_nxt = S_PARITY;
      S_PARITY: if (bit_end) state_nxt = S_STOP;
`else
      S_DATA:   if (bit_end && last_bit) state_nxt = S_STOP;
`endif
      S_STOP: if (bit_end && last_stop) begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = S_START;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Next line level and done pulse; both registered so tx is glitch-free.
  always_comb begin
    tx_d   = tx_q;
    done_d = 1'b0;
    case (state)
      S_IDLE:  if (pop) tx_d = 1'b0;
      S_START: if (bit_end) tx_d = shreg[0];
`ifdef UART_TX_PARITY_EN
      S_DATA:   if (bit_end) tx_d = last_bit ? par_q : shreg[0];
      S_PARITY: if (bit_end) tx_d = 1'b1;
`else
      S_DATA:   if (bit_end) tx_d = last_bit ? 1'b1 : shreg[0];
`endif
      S_STOP: if (bit_end && last_stop) begin
        done_d = 1'b1;
        tx_d   = !pop;
      end
      default: tx_d = 1'b1;
    endcase
  end

  // Bit timer, shifter and frame counters; everything restarts on pop.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
      timer    <= '0;
      div_lat  <= '0;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      tx_q   <= tx_d;
      done_q <= done_d;
      if (pop) begin
        shreg    <= mem[rd_ptr];
        div_lat  <= clock_div;
        timer    <= '0;
        bit_idx  <= '0;
        stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
        par_q    <= (^mem[rd_ptr]) ^ parity_odd;
`endif
      end else if (state != S_IDLE) begin
        timer <= bit_end ? '0 : timer + DIV_WIDTH'(1);
        if (bit_end) begin
          case (state)
            S_START: shreg <= shreg >> 1;
            S_DATA: begin
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + IW'(1);
            end
            S_STOP:  stop_cnt <= stop_cnt + 1'b1;
            default: ;
          endcase
        end
      end
    end
  end

  assign tx      = tx_q;
  assign tx_done = done_q;
  assign tx_busy = (state != S_IDLE);
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: three instances (8N1, 8N2, 5N1).
module tb_uart_tx_fifo;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] clock_div = 16'd0;
  logic        parity_odd = 1'b0;

  always #5 clock = ~clock;

  uart_tx_fifo_if #(.DATA_BITS(8)) ifa ();
  uart_tx_fifo_if #(.DATA_BITS(8)) ifb ();
  uart_tx_fifo_if #(.DATA_BITS(5)) ifc ();

  logic       tx_a, busy_a, done_a;
  logic       tx_b, busy_b, done_b;
  logic       tx_c, busy_c, done_c;
  logic [2:0] cnt_a, cnt_b, cnt_c;

  uart_tx_fifo #(.DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4), .DIV_WIDTH(16)) dut_a (
    .clock(clock), .reset(reset), .clock_div(clock_div), .parity_odd(parity_odd),
    .bus(ifa), .tx(tx_a), .tx_busy(busy_a), .tx_done(done_a), .fifo_count(cnt_a));

  uart_tx_fifo #(.DATA_BITS(8), .STOP_BITS(2), .FIFO_DEPTH(4), .DIV_WIDTH(16)) dut_b (
    .clock(clock), .reset(reset), .clock_div(clock_div), .parity_odd(parity_odd),
    .bus(ifb), .tx(tx_b), .tx_busy(busy_b), .tx_done(done_b), .fifo_count(cnt_b));

  uart_tx_fifo #(.DATA_BITS(5), .STOP_BITS(1), .FIFO_DEPTH(4), .DIV_WIDTH(16)) dut_c (
    .clock(clock), .reset(reset), .clock_div(clock_div), .parity_odd(parity_odd),
    .bus(ifc), .tx(tx_c), .tx_busy(busy_c), .tx_done(done_c), .fifo_count(cnt_c));

  int   total = 0;
  int   bad   = 0;
  int   acc, pulses, lows;
  logic rdy;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Push one word into dut_a while idle and check the whole frame bit by bit.
  task automatic frame_a(input string tag, input logic [7:0] d, input logic [15:0] bits,
                         input int nb, input int per);
    ifa.tx_data  = d;
    ifa.tx_valid = 1'b1;
    tick();
    ifa.tx_valid = 1'b0;
    chk({tag, ".cnt_push"}, cnt_a, 1);
    chk({tag, ".tx_before"}, tx_a, 1);
    tick();
    chk({tag, ".busy"}, busy_a, 1);
    chk({tag, ".cnt_pop"}, cnt_a, 0);
    for (int c = 0; c < nb * per; c++) begin
      chk({tag, ".tx"}, tx_a, bits[c / per]);
      chk({tag, ".done_lo"}, done_a, 0);
      tick();
    end
    chk({tag, ".done_hi"}, done_a, 1);
    chk({tag, ".idle"}, busy_a, 0);
    tick();
    chk({tag, ".done_1cyc"}, done_a, 0);
  endtask

  initial begin
    ifa.tx_valid = 1'b0; ifa.tx_data = '0;
    ifb.tx_valid = 1'b0; ifb.tx_data = '0;
    ifc.tx_valid = 1'b0; ifc.tx_data = '0;

    // reset state
    tick();
    tick();
    chk("rst.tx",    tx_a, 1);
    chk("rst.busy",  busy_a, 0);
    chk("rst.done",  done_a, 0);
    chk("rst.cnt",   cnt_a, 0);
    chk("rst.ready", ifa.tx_ready, 1);
    reset = 1'b0;
    tick();

    // 0xA5 at 4 clocks per bit: 0,1,0,1,0,0,1,0,1,[parity],1
    clock_div = 16'd3;
`ifdef UART_TX_PARITY_EN
    parity_odd = 1'b0;
    frame_a("par_even", 8'hA5, 16'h054A, 11, 4);
    parity_odd = 1'b1;
    frame_a("par_odd", 8'hA5, 16'h074A, 11, 4);
    parity_odd = 1'b0;
`else
    frame_a("a5", 8'hA5, 16'h034A, 10, 4);
`endif

    // 0x00 then 0xFF, two stop bits, 2 clocks per bit, no gap between frames
    clock_div = 16'd1;
    ifb.tx_data  = 8'h00;
    ifb.tx_valid = 1'b1;
    tick();
    chk("b2b.cnt0", cnt_b, 1);
    chk("b2b.tx_idle", tx_b, 1);
    ifb.tx_data = 8'hFF;
    tick();
    ifb.tx_valid = 1'b0;
    chk("b2b.cnt1", cnt_b, 1);
    for (int c = 0; c <= 44; c++) begin
      chk("b2b.tx", tx_b, (c < 18) ? 0 : (c < 22) ? 1 : (c < 24) ? 0 : 1);
      chk("b2b.done", done_b, (c == 22 || c == 44) ? 1 : 0);
      chk("b2b.busy", busy_b, (c < 44) ? 1 : 0);
      tick();
    end
    chk("b2b.cnt_end", cnt_b, 0);

    // 5 data bits, one clock per bit: 0x15 -> 0,1,0,1,0,1,1
    clock_div = 16'd0;
    ifc.tx_data  = 5'h15;
    ifc.tx_valid = 1'b1;
    tick();
    ifc.tx_valid = 1'b0;
    tick();
    for (int c = 0; c < 7; c++) begin
      chk("d5.tx", tx_c, (c == 1 || c == 3 || c >= 5) ? 1 : 0);
      chk("d5.done_lo", done_c, 0);
      tick();
    end
    chk("d5.done_hi", done_c, 1);
    chk("d5.idle", busy_c, 0);

    // Fill during a frame, then reset in the middle of data bit 3
    clock_div = 16'd3;
    ifa.tx_data  = 8'h11;
    ifa.tx_valid = 1'b1;
    tick();
    ifa.tx_valid = 1'b0;
    tick();
    chk("fill.start", tx_a, 0);
    ifa.tx_data  = 8'h31;
    ifa.tx_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      rdy = ifa.tx_ready;
      tick();
      if (rdy) begin
        acc++;
        ifa.tx_data = ifa.tx_data + 8'd1;
      end
    end
    ifa.tx_valid = 1'b0;
    chk("fill.accepted", acc, 4);
    chk("fill.cnt", cnt_a, 4);
    chk("fill.ready", ifa.tx_ready, 0);
    for (int i = 0; i < 11; i++) tick();
    chk("mid.bit3", tx_a, 0);
    chk("mid.busy", busy_a, 1);
    reset = 1'b1;
    tick();
    chk("abort.tx",    tx_a, 1);
    chk("abort.cnt",   cnt_a, 0);
    chk("abort.busy",  busy_a, 0);
    chk("abort.done",  done_a, 0);
    chk("abort.ready", ifa.tx_ready, 1);
    reset = 1'b0;
    pulses = 0;
    lows   = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (done_a) pulses++;
      if (!tx_a) lows++;
    end
    chk("abort.no_done", pulses, 0);
    chk("abort.line_idle", lows, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
